// File: rtl/hazard_unit_ml_pkg.sv
// Shared types and helpers for the load-use hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  localparam int REG_ZERO = 0;

  // Bits needed to hold 0..lat remaining bubbles; never narrower than 1.
  function automatic int rem_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_ml_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit_ml.sv
// Load-use hazard controller beside ID: stalls for LOAD_LAT bubbles per hazard,
// flushes on taken branches and freezes the pipe while data memory is busy.
//
// state    | meaning
// RUN      | normal issue; a detected hazard inserts the first bubble
// LU_STALL | further bubbles pending, rem counts what is left
module hazard_unit_ml
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_memRead,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  input  logic             clr_stats,
  output logic             PCwrite,
  output logic             if_id_write,
  output logic             normalS,
  output logic             if_id_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count
);

  localparam int REM_W = rem_width(LOAD_LAT);

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             hz;
  logic             cnt_inc;

  assign hz = id_ex_memRead && (id_ex_rt != REG_W'(REG_ZERO)) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_inc     = 1'b0;
    PCwrite     = 1'b1;
    if_id_write = 1'b1;
    normalS     = 1'b1;
    if_id_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      state_d = RUN;
      rem_d   = '0;
    end else if (!mem_ready) begin
      // Frozen pipe: bubble accounting resumes once memory catches up.
      PCwrite     = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      normalS     = 1'b0;
      state_d     = RUN;
      rem_d       = '0;
    end else if (state_q == LU_STALL) begin
      PCwrite     = 1'b0;
      if_id_write = 1'b0;
      normalS     = 1'b0;
      cnt_inc     = 1'b1;
      rem_d       = rem_q - REM_W'(1);
      if (rem_q == REM_W'(1)) state_d = RUN;
    end else if (hz) begin
      PCwrite     = 1'b0;
      if_id_write = 1'b0;
      normalS     = 1'b0;
      cnt_inc     = 1'b1;
      if (LOAD_LAT > 1) begin
        state_d = LU_STALL;
        rem_d   = REM_W'(LOAD_LAT - 1);
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (clr_stats),
    .q   (stall_count)
  );

endmodule

// File: tb/tb_hazard_unit_ml.sv
// Drives three hazard_unit_ml variants (LOAD_LAT 1/3/4) with shared stimulus and
// scores each against a bubble-count model through an expected-value queue.
module tb_hazard_unit_ml;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_ex_memRead = 1'b0;
  logic [4:0] id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic       if_id_uses_rt = 1'b0, ex_branch_taken = 1'b0, mem_ready = 1'b1, clr_stats = 1'b0;

  logic [2:0] pcw, ifw, nrm, flu, hld;
  logic [2:0]  cnt0;
  logic [15:0] cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  int          lat[3]  = '{1, 3, 4};
  int unsigned cmax[3] = '{7, 65535, 65535};
  int          bub[3]  = '{0, 0, 0};
  int unsigned mcnt[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_unit_ml #(.REG_W(5), .LOAD_LAT(1), .CNT_W(3)) u_d0 (
    .clk(clk), .rst(rst), .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .PCwrite(pcw[0]), .if_id_write(ifw[0]), .normalS(nrm[0]), .if_id_flush(flu[0]),
    .pipe_hold(hld[0]), .stall_count(cnt0));

  hazard_unit_ml #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .PCwrite(pcw[1]), .if_id_write(ifw[1]), .normalS(nrm[1]), .if_id_flush(flu[1]),
    .pipe_hold(hld[1]), .stall_count(cnt1));

  hazard_unit_ml #(.REG_W(5), .LOAD_LAT(4), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .PCwrite(pcw[2]), .if_id_write(ifw[2]), .normalS(nrm[2]), .if_id_flush(flu[2]),
    .pipe_hold(hld[2]), .stall_count(cnt2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: predict every variant, push, sample mid-cycle, pop and compare.
  task automatic step(input logic r, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ur, input logic br, input logic mrdy,
                      input logic clr);
    logic        hzv, inc;
    logic [4:0]  ctl;
    logic [15:0] ecnt, gcnt;
    logic [20:0] e;
    rst = r; id_ex_memRead = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = ur; ex_branch_taken = br; mem_ready = mrdy; clr_stats = clr;
    hzv = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
    for (int k = 0; k < 3; k++) begin
      inc  = 1'b0;
      ecnt = r ? 16'd0 : 16'(mcnt[k]);
      if (r) begin
        ctl = 5'b11100; bub[k] = 0; mcnt[k] = 0;
      end else if (!mrdy) begin
        ctl = 5'b00101;
      end else if (br) begin
        ctl = 5'b11010; bub[k] = 0;
      end else if (bub[k] > 0) begin
        ctl = 5'b00000; bub[k]--; inc = 1'b1;
      end else if (hzv) begin
        ctl = 5'b00000; bub[k] = lat[k] - 1; inc = 1'b1;
      end else begin
        ctl = 5'b11100;
      end
      if (!r) begin
        if (inc && mcnt[k] < cmax[k]) mcnt[k]++;
        if (clr) mcnt[k] = 0;
      end
      exp_q.push_back({ecnt, ctl});
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      gcnt = (k == 0) ? 16'(cnt0) : (k == 1) ? cnt1 : cnt2;
      check_val($sformatf("d%0d_ctl", k), {27'd0, pcw[k], ifw[k], nrm[k], flu[k], hld[k]},
                {27'd0, e[4:0]});
      check_val($sformatf("d%0d_cnt", k), {16'd0, gcnt}, {16'd0, e[20:5]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);          // reset state
    step(0, 1, 5, 5, 0, 0, 0, 1, 0);          // rs load-use hazard
    idle(4);
    step(0, 1, 5, 5, 0, 0, 0, 1, 0);          // hazard with a memory hold on bubble 2
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);          // $zero never stalls
    idle(1);
    step(0, 1, 7, 3, 7, 0, 0, 1, 0);          // rt match but rt unused
    idle(1);
    step(0, 1, 7, 3, 7, 1, 0, 1, 0);          // rt match and used
    idle(4);
    step(0, 1, 5, 5, 0, 0, 0, 1, 0);          // branch aborts stall on bubble 2
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    step(0, 1, 9, 9, 0, 0, 1, 1, 0);          // hazard and branch together
    idle(1);
    for (int i = 0; i < 9; i++) begin         // drive the narrow counter into saturation
      step(0, 1, 6, 6, 0, 0, 0, 1, 0);
      idle(4);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);          // clear
    idle(1);
    step(0, 1, 6, 6, 0, 0, 0, 1, 1);          // clear coinciding with an increment
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);          // clear during hold
    idle(4);
    step(0, 1, 4, 4, 0, 0, 0, 1, 0);          // reset in the middle of a stall
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) != 0, $urandom_range(0, 19) == 0);
    end
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
